if_fetch_stage: RTL and testbench

//   Instruction-fetch stage directly upstream of the decode stage. Owns the PC, fetches words

---
 rtl/if_fetch_stage_pkg.sv | 21 ++
 rtl/if_fetch_buf.sv | 61 ++++++
 rtl/if_fetch_stage.sv | 101 ++++++++++
 tb/tb_if_fetch_stage.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   if_state_e  : fetch FSM state encoding (2 bits)
//   fetch_ent_t : one buffered {pc, inst} pair
package if_fetch_stage_pkg;
  localparam int          InstAddrBus = 32;
  localparam int          InstBus     = 32;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic        RstEnable   = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2,
    S_DROP = 2'd3
  } if_state_e;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_ent_t;
endpackage

// File: rtl/if_fetch_buf.sv
// Synchronous FIFO of fetched {pc, inst} pairs.
//   clk, rst  : clock, async active-high reset
//   i_push    : write i_data (ignored when full and not popping)
//   i_pop     : retire head (ignored when empty)
//   i_clear   : drop all entries, takes priority over push/pop
//   o_head    : head entry register contents (meaningful only when o_count != 0)
//   o_count   : number of entries held
module if_fetch_buf
  import if_fetch_stage_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_clear,
  input  fetch_ent_t                 i_data,
  output fetch_ent_t                 o_head,
  output logic [$clog2(BUF_DEPTH):0] o_count
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(BUF_DEPTH);

  fetch_ent_t  r_mem [BUF_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push, w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

  // Pointers wrap naturally: depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; the top gates the head with the count.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches from instruction ROM over a
// req/ack handshake, buffers {pc,inst} pairs and presents one per cycle to decode.
// Optional macro IF_STALL_CNT_EN adds stall_cnt_o (saturating count of cycles
// where a valid instruction was held by stall_i).
//   rom_req_o/rom_addr_o/rom_ack_i/rom_data_i : ROM handshake
//   stall_i, flush_i, new_pc_i                : decode backpressure and redirect
//   id_valid_o/id_pc_o/id_inst_o              : presented instruction (zero when invalid)
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   rom_req_o,
  output logic [InstAddrBus-1:0] rom_addr_o,
  input  logic                   rom_ack_i,
  input  logic [InstBus-1:0]     rom_data_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic [InstAddrBus-1:0] new_pc_i,
  output logic                   id_valid_o,
  output logic [InstAddrBus-1:0] id_pc_o,
  output logic [InstBus-1:0]     id_inst_o
`ifdef IF_STALL_CNT_EN
  ,output logic [31:0]           stall_cnt_o
`endif
);
  localparam int AW = $clog2(BUF_DEPTH);

  if_state_e              r_state, w_state_nxt;
  logic [InstAddrBus-1:0] r_fetch_pc, r_drop_addr;
  logic                   w_req, w_ack, w_push, w_pop, w_valid;
  logic [AW:0]            w_count;
  int                     w_cnt_nxt;
  fetch_ent_t             w_head, w_wdata;

  assign w_req   = (r_state == S_REQ) || (r_state == S_DROP);
  assign w_ack   = rom_ack_i && w_req;
  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid && !stall_i && !flush_i;
  assign w_push  = (r_state == S_REQ) && w_ack && !flush_i;
  // Occupancy after this edge, used for the FULL entry/exit decision.
  assign w_cnt_nxt = int'(w_count) + int'(w_push) - int'(w_pop);
  assign w_wdata   = '{pc: r_fetch_pc, inst: rom_data_i};

  if_fetch_buf #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (flush_i),
    .i_data  (w_wdata),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      r_state     <= S_IDLE;
      r_fetch_pc  <= RESET_PC;
      r_drop_addr <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (flush_i)     r_fetch_pc <= {new_pc_i[31:2], 2'b00};
      else if (w_push) r_fetch_pc <= r_fetch_pc + 32'd4;
      // Freeze the outstanding address when a live request gets abandoned;
      // a further flush while already dropping keeps the original.
      if (r_state == S_REQ && w_state_nxt == S_DROP) r_drop_addr <= r_fetch_pc;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ:  if (w_ack) w_state_nxt = (w_cnt_nxt >= BUF_DEPTH) ? S_FULL : S_REQ;
      S_FULL: if (w_cnt_nxt < BUF_DEPTH) w_state_nxt = S_REQ;
      S_DROP: if (w_ack) w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
    // Redirect wins: an unacked live request must still complete, so drain it.
    if (flush_i) w_state_nxt = (w_req && !rom_ack_i) ? S_DROP : S_REQ;
  end

  assign rom_req_o  = w_req;
  assign rom_addr_o = (r_state == S_DROP) ? r_drop_addr : r_fetch_pc;
  assign id_valid_o = w_valid;
  assign id_pc_o    = w_valid ? w_head.pc   : ZeroWord;
  assign id_inst_o  = w_valid ? w_head.inst : ZeroWord;

`ifdef IF_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable)                              r_stall_cnt <= '0;
    else if (w_valid && stall_i && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
  end
  assign stall_cnt_o = r_stall_cnt;
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_ack_i;
  logic [31:0] rom_data_i;
  logic        stall_i, flush_i;
  logic [31:0] new_pc_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o, id_inst_o;
`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  int errors = 0;
  int checks = 0;
  logic auto_rom = 1'b0;

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rom_req_o  (rom_req_o),
    .rom_addr_o (rom_addr_o),
    .rom_ack_i  (rom_ack_i),
    .rom_data_i (rom_data_i),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .new_pc_i   (new_pc_i),
    .id_valid_o (id_valid_o),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o)
`ifdef IF_STALL_CNT_EN
    ,.stall_cnt_o (stall_cnt_o)
`endif
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock; sample point is 1 time unit after the rising edge.
  // With auto_rom set, a ROM model acks every live request once.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_rom) begin
      if (rom_ack_i) rom_ack_i = 1'b0;
      else if (rom_req_o) begin
        rom_ack_i  = 1'b1;
        rom_data_i = rom_word(rom_addr_o);
      end
    end
  endtask

  task automatic do_reset();
    rom_ack_i = 0; rom_data_i = 0; stall_i = 0; flush_i = 0; new_pc_i = 0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  typedef struct {
    logic        ack;
    logic [31:0] data;
    logic        stall;
    logic        flush;
    logic [31:0] npc;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  vec_t tbl[22];

  initial begin
    logic [31:0] exp_pc, held_pc;
    logic        held_v, saw_drop;
    int          pops;

    tbl[0]  = '{0, 0, 0, 0, 0,            1, 32'h0,   0, 0, 0};
    tbl[1]  = '{1, rom_word(32'h0), 0, 0, 0,   1, 32'h4,   1, 32'h0, rom_word(32'h0)};
    tbl[2]  = '{1, rom_word(32'h4), 0, 0, 0,   1, 32'h8,   1, 32'h4, rom_word(32'h4)};
    tbl[3]  = '{0, 0, 1, 0, 0,            1, 32'h8,   1, 32'h4, rom_word(32'h4)};
    tbl[4]  = '{1, rom_word(32'h8), 1, 0, 0,   0, 32'h0,   1, 32'h4, rom_word(32'h4)};
    tbl[5]  = '{1, 32'hDEAD_BEEF, 1, 0, 0,     0, 32'h0,   1, 32'h4, rom_word(32'h4)};
    tbl[6]  = '{0, 0, 0, 0, 0,            1, 32'hC,   1, 32'h8, rom_word(32'h8)};
    tbl[7]  = '{0, 0, 0, 0, 0,            1, 32'hC,   0, 0, 0};
    tbl[8]  = '{1, rom_word(32'hC), 1, 0, 0,   1, 32'h10,  1, 32'hC, rom_word(32'hC)};
    tbl[9]  = '{0, 0, 1, 1, 32'h103,      1, 32'h10,  0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0,            1, 32'h10,  0, 0, 0};
    tbl[11] = '{1, 32'hBAD0_BAD0, 0, 0, 0,     1, 32'h100, 0, 0, 0};
    tbl[12] = '{1, rom_word(32'h100), 0, 0, 0, 1, 32'h104, 1, 32'h100, rom_word(32'h100)};
    tbl[13] = '{1, rom_word(32'h104), 1, 1, 32'h200, 1, 32'h200, 0, 0, 0};
    tbl[14] = '{1, rom_word(32'h200), 0, 0, 0, 1, 32'h204, 1, 32'h200, rom_word(32'h200)};
    tbl[15] = '{0, 0, 0, 1, 32'h300,      1, 32'h204, 0, 0, 0};
    tbl[16] = '{0, 0, 0, 1, 32'h400,      1, 32'h204, 0, 0, 0};
    tbl[17] = '{1, 32'hBAD1_BAD1, 0, 0, 0,     1, 32'h400, 0, 0, 0};
    tbl[18] = '{1, rom_word(32'h400), 0, 0, 0, 1, 32'h404, 1, 32'h400, rom_word(32'h400)};
    tbl[19] = '{1, rom_word(32'h404), 0, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFC, 0, 0, 0};
    tbl[20] = '{1, rom_word(32'hFFFF_FFFC), 0, 0, 0, 1, 32'h0, 1, 32'hFFFF_FFFC, rom_word(32'hFFFF_FFFC)};
    tbl[21] = '{1, rom_word(32'h0), 0, 0, 0,   1, 32'h4,   1, 32'h0, rom_word(32'h0)};

    // Reset state
    rom_ack_i = 0; rom_data_i = 0; stall_i = 0; flush_i = 0; new_pc_i = 0;
    rst = 1'b1;
    #12;
    chk("rst_req",   {31'b0, rom_req_o},  32'h0);
    chk("rst_addr",  rom_addr_o,          32'h0);
    chk("rst_valid", {31'b0, id_valid_o}, 32'h0);
    chk("rst_pc",    id_pc_o,             32'h0);
    chk("rst_inst",  id_inst_o,           32'h0);
`ifdef IF_STALL_CNT_EN
    chk("rst_scnt",  stall_cnt_o,         32'h0);
`endif
    rst = 1'b0;

    // Cycle-by-cycle directed vectors
    for (int i = 0; i < 22; i++) begin
      rom_ack_i = tbl[i].ack; rom_data_i = tbl[i].data; stall_i = tbl[i].stall;
      flush_i = tbl[i].flush; new_pc_i = tbl[i].npc;
      tick();
      chk($sformatf("v%0d_req", i), {31'b0, rom_req_o}, {31'b0, tbl[i].req});
      if (tbl[i].req) chk($sformatf("v%0d_addr", i), rom_addr_o, tbl[i].addr);
      chk($sformatf("v%0d_valid", i), {31'b0, id_valid_o}, {31'b0, tbl[i].vld});
      chk($sformatf("v%0d_pc", i),   id_pc_o,   tbl[i].pc);
      chk($sformatf("v%0d_inst", i), id_inst_o, tbl[i].inst);
    end

    // Streaming with a ROM model, 6-cycle stall window in the middle
    do_reset();
    auto_rom = 1'b1;
    exp_pc = 0; held_pc = 0; held_v = 0; saw_drop = 0; pops = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      stall_i = (i >= 20 && i < 26);
      if (stall_i) begin
        if (i == 20) begin held_pc = id_pc_o; held_v = id_valid_o; end
        else if (held_v) chk("stall_hold_pc", id_pc_o, held_pc);
        if (!rom_req_o) saw_drop = 1'b1;
      end
      if (id_valid_o && !stall_i) begin
        chk("stream_pc",   id_pc_o,   exp_pc);
        chk("stream_inst", id_inst_o, rom_word(exp_pc));
        exp_pc = exp_pc + 4;
        pops++;
      end
    end
    chk("stall_req_drop", {31'b0, saw_drop}, 32'h1);
    chk("stream_progress", {31'b0, pops >= 20}, 32'h1);

    // Asynchronous reset between edges with a request outstanding
    auto_rom = 1'b0; rom_ack_i = 0; stall_i = 0;
    for (int k = 0; k < 4 && !rom_req_o; k++) tick();
    chk("pre_arst_req", {31'b0, rom_req_o}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req",   {31'b0, rom_req_o},  32'h0);
    chk("arst_addr",  rom_addr_o,          32'h0);
    chk("arst_valid", {31'b0, id_valid_o}, 32'h0);
    chk("arst_inst",  id_inst_o,           32'h0);
    rst = 1'b0;
    tick();
    chk("post_arst_req",  {31'b0, rom_req_o}, 32'h1);
    chk("post_arst_addr", rom_addr_o,         32'h0);

`ifdef IF_STALL_CNT_EN
    // 5 stalled valid cycles, then 3 stalled empty cycles
    do_reset();
    tick();
    rom_ack_i = 1; rom_data_i = rom_word(32'h0);
    tick();
    rom_ack_i = 0; stall_i = 1;
    repeat (5) tick();
    chk("scnt_5", stall_cnt_o, 32'd5);
    stall_i = 0; flush_i = 1; new_pc_i = 32'h40;
    tick();
    flush_i = 0; stall_i = 1;
    repeat (3) tick();
    chk("scnt_empty_valid", {31'b0, id_valid_o}, 32'h0);
    chk("scnt_final", stall_cnt_o, 32'd5);
    stall_i = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
